round_key_sequencer: RTL

ROUND_KEY_SEQUENCER -- requirements
Module: round_key_sequencer

---
 rtl/round_key_if.sv | 29 ++
 rtl/round_key_sequencer.sv | 77 +++++++
 2 files changed

// File: rtl/round_key_if.sv
// Handshake bundle between the key generator / round engine and round_key_sequencer.
// The master side drives the key set and controls; the slave side is the sequencer.
interface round_key_if #(parameter int KEY_W = 48);
    logic             load;
    logic             decrypt;
    logic             flush;
    logic             key_ready;
    logic [KEY_W-1:0] r_key1,  r_key2,  r_key3,  r_key4,  r_key5,  r_key6,  r_key7,  r_key8;
    logic [KEY_W-1:0] r_key9,  r_key10, r_key11, r_key12, r_key13, r_key14, r_key15, r_key16;
    logic             key_valid;
    logic [KEY_W-1:0] key_out;
    logic [3:0]       round_idx;
    logic             last;
    logic             busy;

    modport master (
        output load, decrypt, flush, key_ready,
        output r_key1, r_key2, r_key3, r_key4, r_key5, r_key6, r_key7, r_key8,
        output r_key9, r_key10, r_key11, r_key12, r_key13, r_key14, r_key15, r_key16,
        input  key_valid, key_out, round_idx, last, busy
    );

    modport slave (
        input  load, decrypt, flush, key_ready,
        input  r_key1, r_key2, r_key3, r_key4, r_key5, r_key6, r_key7, r_key8,
        input  r_key9, r_key10, r_key11, r_key12, r_key13, r_key14, r_key15, r_key16,
        output key_valid, key_out, round_idx, last, busy
    );
endinterface

// File: rtl/round_key_sequencer.sv
// Latches a parallel round-key set and streams it one key per accepted transfer,
// ascending for encrypt or descending for decrypt; storage is wiped when the stream ends.
module round_key_sequencer #(
    parameter int KEY_W  = 48,
    parameter int ROUNDS = 16
) (
    input  logic      CLK,
    input  logic      RST_N,
    round_key_if.slave bus
);
    typedef enum logic {IDLE, STREAM} state_e;

    localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

    state_e                   state_q, state_d;
    logic [15:0][KEY_W-1:0]   store_q, store_d;
    logic                     dec_q, dec_d;
    logic [3:0]               idx_q, idx_d;
    logic [15:0][KEY_W-1:0]   keys_in;
    logic [3:0]               sel;

    assign keys_in = {bus.r_key16, bus.r_key15, bus.r_key14, bus.r_key13,
                      bus.r_key12, bus.r_key11, bus.r_key10, bus.r_key9,
                      bus.r_key8,  bus.r_key7,  bus.r_key6,  bus.r_key5,
                      bus.r_key4,  bus.r_key3,  bus.r_key2,  bus.r_key1};

    always_comb begin
        state_d = state_q;
        store_d = store_q;
        dec_d   = dec_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.load && !bus.flush) begin
                    state_d = STREAM;
                    store_d = keys_in;
                    dec_d   = bus.decrypt;
                    idx_d   = '0;
                end
            end
            STREAM: begin
                // Flush outranks any transfer; both exits wipe the key material.
                if (bus.flush || (bus.key_ready && idx_q == LAST_IDX)) begin
                    state_d = IDLE;
                    store_d = '0;
                    dec_d   = 1'b0;
                    idx_d   = '0;
                end else if (bus.key_ready) begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            store_q <= '0;
            dec_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            dec_q   <= dec_d;
            idx_q   <= idx_d;
        end
    end

    // Storage is zero whenever IDLE, so key_out needs no extra gating.
    assign sel           = dec_q ? (LAST_IDX - idx_q) : idx_q;
    assign bus.key_out   = store_q[sel];
    assign bus.key_valid = (state_q == STREAM);
    assign bus.busy      = (state_q == STREAM);
    assign bus.round_idx = idx_q;
    assign bus.last      = (state_q == STREAM) && (idx_q == LAST_IDX);
endmodule
